buyruk_getirici: RTL
====================

// Module: buyruk_getirici
// PURPOSE
//  Instruction-fetch stage directly upstream of the single-cycle core. It takes the core's
//  program_sayaci, reads the word from instruction memory over a valid/ready request and a
//  valid response channel, and presents it on buyruk with a one-cycle buyruk_gecerli strobe.
//  The core advances its PC and register file only on the edge where buyruk_gecerli=1.
//  Words pass through in raw memory byte order; the byte swap is done inside the core.
// PARAMETERS
//  ADRES_TABANI   32'h0000_0000  added to program_sayaci to form bellek_adres
//  ZAMAN_ASIMI    64             max cycles in BEKLE before a timeout error (>=1)
//  SATIR_SAYISI   8              buffer entries, power of 2 (used only with GETIR_ONBELLEK_EN)
// PORTS
//  saat                  in   1   clock, rising edge
//  reset                 in   1   reset, synchronous, active-high
//  program_sayaci        in   32  PC from core; stable while buyruk_gecerli=0
//  buyruk                out  32  fetched word, raw memory byte order
//  buyruk_gecerli        out  1   buyruk valid; core consumes on this edge
//  buyruk_hata           out  1   sticky fetch error (misaligned PC, bus error, timeout)
//  bellek_istek_gecerli  out  1   memory read request valid
//  bellek_istek_hazir    in   1   memory accepts request
//  bellek_adres          out  32  request address = program_sayaci + ADRES_TABANI
//  bellek_yanit_gecerli  in   1   response valid (single-cycle pulse, no back-pressure)
//  bellek_yanit_veri     in   32  response data
//  bellek_yanit_hata     in   1   response is a bus error (qualified by yanit_gecerli)
// BEHAVIOUR
//  Reset: state=BOSTA; buyruk=0, buyruk_gecerli=0, buyruk_hata=0, bellek_istek_gecerli=0,
//   bellek_adres=0, timeout counter=0. Reset mid-transaction abandons it immediately.
//  FSM states:
//   BOSTA : one cycle after reset -> ISTEK.
//   ISTEK : if program_sayaci[1:0]!=0 -> HATA, no request issued. Otherwise drive
//           istek_gecerli=1 and bellek_adres. On istek_gecerli&&istek_hazir -> BEKLE.
//           gecerli/adres stay stable until accepted (no withdrawal).
//   BEKLE : counter increments each cycle. On yanit_gecerli: if yanit_hata -> HATA,
//           else capture veri into buyruk -> HAZIR. If counter reaches ZAMAN_ASIMI with no
//           response -> HATA. A response in the same cycle as the limit wins over timeout.
//   HAZIR : buyruk_gecerli=1 for exactly one cycle, then -> ISTEK with counter cleared.
//           Core presents its new PC in the following cycle.
//   HATA  : buyruk_hata=1, buyruk_gecerli=0, no requests. Sticky until reset.
//  Latency: zero-wait memory (hazir=1, response one cycle after accept) -> ISTEK at c0,
//   BEKLE at c1, buyruk_gecerli at c2. Throughput: one instruction per 3 cycles.
//  buyruk keeps its last captured value outside HAZIR. It is not cleared.
//  yanit_gecerli outside BEKLE is dropped silently. Memory is required to flush pending
//   responses on the same reset.
//  Address add wraps modulo 2^32. Unused low PC bits are not masked.
// CONFIGURATION
//  GETIR_ONBELLEK_EN defined: direct-mapped SATIR_SAYISI-entry buffer. Index = PC[2+:log2 N],
//   tag = remaining upper PC bits, plus a valid bit. In ISTEK a hit goes to HAZIR on the next
//   cycle with no memory request (1-cycle latency). Every error-free response fills the
//   entry. All valid bits are cleared on reset. Error responses are not cached.
//   Misaligned-PC detection still takes priority over a hit.
//  GETIR_ONBELLEK_EN undefined: no buffer, and every fetch goes to memory.
// STRUCTURE
//  Package getir_paket: state encoding (BOSTA, ISTEK, BEKLE, HAZIR, HATA as 3-bit localparams)
//   and the hizalama-check constant.
//  Sub-module getir_onbellek (tag/data/valid arrays, lookup, fill). It is instantiated only
//   under GETIR_ONBELLEK_EN. The FSM stays in buyruk_getirici.
// TESTING
//  1 Reset, PC=0, hazir=1, response 1 cycle after accept with 32'h33_05_00_00
//    -> adres=0, buyruk=32'h33050000, gecerli exactly 1 cycle at c2.
//  2 ADRES_TABANI=32'h1000, PC=8, hazir low 3 cycles -> request held stable with adres=32'h1008.
//    Fetch completes after acceptance.
//  3 PC=32'h6 -> buyruk_hata=1 next cycle, no istek_gecerli ever.
//    Stays set until reset; reset clears it.
//  4 ZAMAN_ASIMI=4, no response -> HATA after 4 BEKLE cycles.
//    A response arriving later is ignored.
//  5 Response with yanit_hata=1 -> buyruk_hata=1, buyruk_gecerli never asserted.
//    Reset asserted in BEKLE -> BOSTA, all outputs at reset values.
//  6 (GETIR_ONBELLEK_EN) loop PC 0->4->0: second fetch of PC=0 issues no request.
//    buyruk_gecerli arrives 1 cycle after entering ISTEK.

Source files
------------

// File: rtl/getir_paket.sv
// Shared definitions for the instruction-fetch stage: state codes, widths and the
// word-alignment check.
package getir_paket;

   localparam int unsigned VERI_W   = 32;
   localparam int unsigned SOZCUK_W = VERI_W - 2;
   localparam int unsigned DURUM_W  = 3;

   typedef logic [DURUM_W-1:0] durum_t;

   localparam durum_t BOSTA = 3'd0;
   localparam durum_t ISTEK = 3'd1;
   localparam durum_t BEKLE = 3'd2;
   localparam durum_t HAZIR = 3'd3;
   localparam durum_t HATA  = 3'd4;

   // Low PC bits of a word-aligned instruction address
   localparam logic [1:0] HIZALAMA_SIFIR = 2'b00;

   function automatic logic hizali_mi(input logic [1:0] alt_bitler);
      return alt_bitler == HIZALAMA_SIFIR;
   endfunction

endpackage

// File: rtl/getir_onbellek.sv
// Direct-mapped instruction buffer for the fetch stage (used only when GETIR_ONBELLEK_EN
// is defined). Index is the low word-address bits, tag is the rest; lookup is
// combinational, fill and valid-clear are synchronous.
module getir_onbellek
   import getir_paket::*;
#(
   parameter int unsigned SATIR_SAYISI = 8
)(
   input  logic                saat,
   input  logic                reset,
   input  logic [SOZCUK_W-1:0] i_okuma_sozcuk,
   output logic                o_isabet_c,
   output logic [VERI_W-1:0]   o_veri_c,
   input  logic                i_yazma_en,
   input  logic [SOZCUK_W-1:0] i_yazma_sozcuk,
   input  logic [VERI_W-1:0]   i_yazma_veri
);

   localparam int unsigned IDX_W    = $clog2(SATIR_SAYISI);
   localparam int unsigned ETIKET_W = SOZCUK_W - IDX_W;

   logic [SATIR_SAYISI-1:0] r_gecerli;
   logic [ETIKET_W-1:0]     r_etiket [SATIR_SAYISI];
   logic [VERI_W-1:0]       r_veri   [SATIR_SAYISI];

   logic [IDX_W-1:0]    w_oku_idx;
   logic [ETIKET_W-1:0] w_oku_etiket;
   logic [IDX_W-1:0]    w_yaz_idx;
   logic [ETIKET_W-1:0] w_yaz_etiket;

   assign w_oku_idx    = i_okuma_sozcuk[IDX_W-1:0];
   assign w_oku_etiket = i_okuma_sozcuk[SOZCUK_W-1:IDX_W];
   assign w_yaz_idx    = i_yazma_sozcuk[IDX_W-1:0];
   assign w_yaz_etiket = i_yazma_sozcuk[SOZCUK_W-1:IDX_W];

   assign o_isabet_c = r_gecerli[w_oku_idx] && (r_etiket[w_oku_idx] == w_oku_etiket);
   assign o_veri_c   = r_veri[w_oku_idx];

   // Valid bits: cleared on reset, set on every fill
   always_ff @(posedge saat) begin
      if (reset) begin
         r_gecerli <= '0;
      end else if (i_yazma_en) begin
         r_gecerli[w_yaz_idx] <= 1'b1;
      end
   end

   // Tag and data arrays need no reset; valid bits guard them
   always_ff @(posedge saat) begin
      if (i_yazma_en) begin
         r_etiket[w_yaz_idx] <= w_yaz_etiket;
         r_veri[w_yaz_idx]   <= i_yazma_veri;
      end
   end

endmodule

// File: rtl/buyruk_getirici.sv
// Instruction-fetch stage in front of the single-cycle core. Reads the word at
// program_sayaci + ADRES_TABANI over a valid/ready request and a valid response channel
// and presents it with a one-cycle buyruk_gecerli strobe. Errors (misaligned PC, bus
// error, timeout) are sticky until reset.
// Optional build macro: GETIR_ONBELLEK_EN adds a direct-mapped SATIR_SAYISI-entry buffer.
module buyruk_getirici
   import getir_paket::*;
#(
   parameter logic [VERI_W-1:0] ADRES_TABANI = 32'h0000_0000,
   parameter int unsigned       ZAMAN_ASIMI  = 64,
   parameter int unsigned       SATIR_SAYISI = 8
)(
   input  logic              saat,
   input  logic              reset,
   input  logic [VERI_W-1:0] program_sayaci,
   output logic [VERI_W-1:0] buyruk,
   output logic              buyruk_gecerli,
   output logic              buyruk_hata,
   output logic              bellek_istek_gecerli,
   input  logic              bellek_istek_hazir,
   output logic [VERI_W-1:0] bellek_adres,
   input  logic              bellek_yanit_gecerli,
   input  logic [VERI_W-1:0] bellek_yanit_veri,
   input  logic              bellek_yanit_hata
);

   localparam int unsigned SAYAC_W = $clog2(ZAMAN_ASIMI + 1);

   if (ZAMAN_ASIMI < 1 || SATIR_SAYISI < 2 ||
       (SATIR_SAYISI & (SATIR_SAYISI - 1)) != 0) begin : g_parametre_hatasi
      $error("buyruk_getirici: ZAMAN_ASIMI must be >=1 and SATIR_SAYISI a power of 2 >= 2");
   end

   durum_t             r_durum;
   durum_t             w_sonraki;
   logic [SAYAC_W-1:0] r_sayac;
   logic [VERI_W-1:0]  r_buyruk;

   logic              w_hizali;
   logic              w_zaman_doldu;
   logic              w_yanit_iyi;
   logic              w_isabet;
   logic [VERI_W-1:0] w_onbellek_veri;
   logic              w_istek_gecerli;
   logic [VERI_W-1:0] w_adres;
   logic              w_buyruk_gecerli;
   logic              w_buyruk_hata;

   assign w_hizali      = hizali_mi(program_sayaci[1:0]);
   assign w_zaman_doldu = (r_sayac == SAYAC_W'(ZAMAN_ASIMI - 1));
   assign w_yanit_iyi   = bellek_yanit_gecerli && !bellek_yanit_hata;

`ifdef GETIR_ONBELLEK_EN
   logic w_doldur;

   // Every error-free response fills the buffer; the PC is still the fetched one
   assign w_doldur = (r_durum == BEKLE) && w_yanit_iyi;

   getir_onbellek #(
      .SATIR_SAYISI (SATIR_SAYISI)
   ) u_onbellek (
      .saat           (saat),
      .reset          (reset),
      .i_okuma_sozcuk (program_sayaci[VERI_W-1:2]),
      .o_isabet_c     (w_isabet),
      .o_veri_c       (w_onbellek_veri),
      .i_yazma_en     (w_doldur),
      .i_yazma_sozcuk (program_sayaci[VERI_W-1:2]),
      .i_yazma_veri   (bellek_yanit_veri)
   );
`else
   assign w_isabet        = 1'b0;
   assign w_onbellek_veri = '0;
`endif

   // State register
   always_ff @(posedge saat) begin
      if (reset) begin
         r_durum <= BOSTA;
      end else begin
         r_durum <= w_sonraki;
      end
   end

   // Next-state logic; misalignment beats a buffer hit, a response beats the timeout
   always_comb begin
      w_sonraki = r_durum;
      case (r_durum)
         BOSTA: w_sonraki = ISTEK;
         ISTEK: begin
            if (!w_hizali) begin
               w_sonraki = HATA;
            end else if (w_isabet) begin
               w_sonraki = HAZIR;
            end else if (bellek_istek_hazir) begin
               w_sonraki = BEKLE;
            end
         end
         BEKLE: begin
            if (bellek_yanit_gecerli) begin
               w_sonraki = bellek_yanit_hata ? HATA : HAZIR;
            end else if (w_zaman_doldu) begin
               w_sonraki = HATA;
            end
         end
         HAZIR:   w_sonraki = ISTEK;
         HATA:    w_sonraki = HATA;
         default: w_sonraki = BOSTA;
      endcase
   end

   // Output decode; the request is held for as long as ISTEK waits for acceptance
   always_comb begin
      w_istek_gecerli  = 1'b0;
      w_adres          = '0;
      w_buyruk_gecerli = 1'b0;
      w_buyruk_hata    = 1'b0;
      case (r_durum)
         ISTEK: begin
            w_istek_gecerli = w_hizali && !w_isabet;
            w_adres         = program_sayaci + ADRES_TABANI;
         end
         HAZIR:   w_buyruk_gecerli = 1'b1;
         HATA:    w_buyruk_hata    = 1'b1;
         default: ;
      endcase
   end

   // Timeout counter and fetched-word register
   always_ff @(posedge saat) begin
      if (reset) begin
         r_sayac  <= '0;
         r_buyruk <= '0;
      end else begin
         if (r_durum == BEKLE) begin
            r_sayac <= r_sayac + SAYAC_W'(1);
         end else begin
            r_sayac <= '0;
         end
         if (r_durum == BEKLE && w_yanit_iyi) begin
            r_buyruk <= bellek_yanit_veri;
         end else if (r_durum == ISTEK && w_hizali && w_isabet) begin
            r_buyruk <= w_onbellek_veri;
         end
      end
   end

   assign buyruk               = r_buyruk;
   assign buyruk_gecerli       = w_buyruk_gecerli;
   assign buyruk_hata          = w_buyruk_hata;
   assign bellek_istek_gecerli = w_istek_gecerli;
   assign bellek_adres         = w_adres;

endmodule
